// File: rtl/reader_ring_buf.sv
// DEPTH-entry circular buffer with push/pop, head-of-buffer data and occupancy.
// Pointers wrap explicitly at DEPTH-1 so non-power-of-2 depths work.
module reader_ring_buf #(
  parameter int  DATA_WIDTH = 32,
  parameter int  DEPTH      = 3,
  localparam int PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [CNT_W-1:0]      count
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  // NOTE: storage is deliberately not reset; occupancy gates every read of it.
  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_std_axis_reader.sv
// Standard-mode (non-FWFT) native FIFO read port to AXIS manager, read latency 1 or 2.
// Credit-based read issue into a small ring buffer; m_axis_tready never reaches fifo_rd_en.
module fifo_std_axis_reader #(
  parameter int    DATA_WIDTH   = 32,
  parameter int    READ_LATENCY = 1,
  parameter string ALWAYS_VALID = "FALSE",
  // Occupancy spans 0..READ_LATENCY+2: 2 bits at latency 1, 3 bits at latency 2.
  localparam int   CNT_W        = $clog2(READ_LATENCY + 3)
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [CNT_W-1:0]      buf_count,
  output logic                  underflow
);

  localparam int DEPTH = READ_LATENCY + 2;
  localparam int OCC_W = 3;
  localparam bit AV    = (ALWAYS_VALID == "TRUE");

  if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_latency
    $error("fifo_std_axis_reader: READ_LATENCY must be 1 or 2");
  end

  logic [READ_LATENCY-1:0] land_pipe;
  logic [OCC_W-1:0]        inflight;
  logic [OCC_W-1:0]        occupancy;
  logic [DATA_WIDTH-1:0]   head;
  logic                    land;
  logic                    pop;
  logic                    buf_empty;

  reader_ring_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ring (
    .aclk     (aclk),
    .areset   (areset),
    .push     (land),
    .push_data(fifo_dout),
    .pop      (pop),
    .head     (head),
    .count    (buf_count)
  );

  // Credit uses registered state only, so a same-cycle pop never frees a slot.
  always_comb begin
    // NOTE: defaults first so no branch leaves an output unassigned (no latch).
    occupancy  = OCC_W'(buf_count) + inflight;
    fifo_rd_en = 1'b0;
    if (!areset && enable && !fifo_empty && (occupancy < OCC_W'(DEPTH))) begin
      fifo_rd_en = 1'b1;
    end
  end

  assign land      = land_pipe[READ_LATENCY-1];
  assign buf_empty = (buf_count == '0);
  assign pop       = m_axis_tready && !buf_empty;

  assign m_axis_tvalid = AV ? 1'b1 : !buf_empty;
  assign m_axis_tdata  = buf_empty ? '0 : head;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      land_pipe <= '0;
      inflight  <= '0;
      underflow <= 1'b0;
    end else begin
      land_pipe <= (land_pipe << 1) | READ_LATENCY'(fifo_rd_en);
      case ({fifo_rd_en, land})
        2'b10:   inflight <= inflight + OCC_W'(1);
        2'b01:   inflight <= inflight - OCC_W'(1);
        default: inflight <= inflight;
      endcase
      underflow <= AV && m_axis_tready && buf_empty;
    end
  end

endmodule

// File: tb/tb_fifo_std_axis_reader.sv
// Scoreboard bench: three readers (latency 1, latency 2, latency 1 always-valid) each fed
// by a standard-mode FIFO model; stimulus queues expected words, per-channel monitors check them.
module tb_fifo_std_axis_reader;

  localparam int N = 3;

  typedef struct {
    int          ch;
    logic [31:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        enable     [N];
  logic        tready     [N];
  logic        fifo_rd_en [N];
  logic        tvalid     [N];
  logic        underflow  [N];
  logic [31:0] tdata      [N];
  logic [2:0]  buf_count  [N];
  logic [31:0] fmem       [N][64];
  int          wp         [N];
  exp_t        exp_q [$];
  int          n_total = 0;
  int          n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
  endtask

  for (genvar g = 0; g < N; g++) begin : gen_ch
    localparam int L  = (g == 1) ? 2 : 1;
    localparam int D  = L + 2;
    localparam int CW = $clog2(D + 1);

    logic          rd_en;
    logic          empty;
    logic          valid;
    logic          uflow;
    logic          rd_d;
    logic [31:0]   dout;
    logic [31:0]   s1;
    logic [31:0]   data;
    logic [CW-1:0] bc;
    int            rp = 0;

    assign empty         = (rp == wp[g]);
    assign fifo_rd_en[g] = rd_en;
    assign tvalid[g]     = valid;
    assign underflow[g]  = uflow;
    assign tdata[g]      = data;
    assign buf_count[g]  = 3'(bc);

    // Standard-mode FIFO model: dout is valid L edges after rd_en is sampled.
    always @(posedge clk) begin
      if (rst) rp <= wp[g];
      else if (rd_en) rp <= rp + 1;
      if (rd_en) s1 <= fmem[g][rp % 64];
      rd_d <= rd_en;
      if (L == 1) begin
        if (rd_en) dout <= fmem[g][rp % 64];
      end else if (rd_d) begin
        dout <= s1;
      end
    end

    if (g == 2) begin : g_av
      fifo_std_axis_reader #(.DATA_WIDTH(32), .READ_LATENCY(L), .ALWAYS_VALID("TRUE")) u_dut (
        .aclk(clk), .areset(rst), .enable(enable[g]), .fifo_empty(empty), .fifo_rd_en(rd_en),
        .fifo_dout(dout), .m_axis_tdata(data), .m_axis_tvalid(valid),
        .m_axis_tready(tready[g]), .buf_count(bc), .underflow(uflow));
      always @(negedge clk) if (!rst) check("land_into_full", 32'(u_dut.land && bc == CW'(D)), 0);
    end else begin : g_std
      fifo_std_axis_reader #(.DATA_WIDTH(32), .READ_LATENCY(L), .ALWAYS_VALID("FALSE")) u_dut (
        .aclk(clk), .areset(rst), .enable(enable[g]), .fifo_empty(empty), .fifo_rd_en(rd_en),
        .fifo_dout(dout), .m_axis_tdata(data), .m_axis_tvalid(valid),
        .m_axis_tready(tready[g]), .buf_count(bc), .underflow(uflow));
      always @(negedge clk) if (!rst) check("land_into_full", 32'(u_dut.land && bc == CW'(D)), 0);
    end

    always @(negedge clk) begin : mon
      exp_t e;
      if (!rst) begin
        check("rd_en_while_empty", 32'(rd_en && empty), 0);
        check("count_le_depth", 32'(bc <= CW'(D)), 1);
        check("valid_rule", 32'(valid), 32'((g == 2) || (bc != '0)));
        if (valid && tready[g] && bc != '0) begin
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL sb_extra ch%0d: got 0x%0h, required no word at %0t", g, data, $time);
          end else begin
            e = exp_q.pop_front();
            check("sb_channel", 32'(g), 32'(e.ch));
            check("sb_data", data, e.d);
          end
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input int c, input logic [31:0] d, input bit track);
    exp_t e;
    fmem[c][wp[c] % 64] = d;
    wp[c]++;
    if (track) begin
      e.ch = c;
      e.d  = d;
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int c = 0; c < N; c++) begin
      enable[c] = 1'b0;
      tready[c] = 1'b0;
    end
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    check(name, 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < N; c++) begin
      enable[c] = 1'b0;
      tready[c] = 1'b0;
      wp[c]     = 0;
    end

    // Reset values, with a non-empty FIFO and enable high to exercise rd_en gating.
    load(0, 32'hFFFF_0000, 1'b0);
    enable[0] = 1'b1;
    tick(2);
    check("rst_rd_en", 32'(fifo_rd_en[0]), 0);
    check("rst_tvalid", 32'(tvalid[0]), 0);
    check("rst_tdata", tdata[0], 0);
    check("rst_buf_count", 32'(buf_count[0]), 0);
    check("rst_underflow", 32'(underflow[0]), 0);
    check("rst_av_tvalid", 32'(tvalid[2]), 1);
    check("rst_av_tdata", tdata[2], 0);

    // Latency 1 streaming: 16 words back-to-back after the first.
    do_reset();
    tready[0] = 1'b1;
    for (int i = 0; i < 16; i++) load(0, 32'(i), 1'b1);
    enable[0] = 1'b1;
    #1;
    check("t1_rd_en_first", 32'(fifo_rd_en[0]), 1);
    tick();
    check("t1_valid_after_e0", 32'(tvalid[0]), 0);
    tick();
    for (int k = 0; k < 16; k++) begin
      check("t1_b2b_valid", 32'(tvalid[0]), 1);
      check("t1_b2b_data", tdata[0], 32'(k));
      tick();
    end
    check("t1_valid_done", 32'(tvalid[0]), 0);
    drain("t1_drain", 10);

    // Backpressure: buffer fills to depth 3 and holds its head.
    do_reset();
    for (int i = 0; i < 10; i++) load(0, 32'(i), 1'b1);
    enable[0] = 1'b1;
    tick(20);
    check("t3_buf_full", 32'(buf_count[0]), 3);
    check("t3_rd_en_off", 32'(fifo_rd_en[0]), 0);
    check("t3_valid", 32'(tvalid[0]), 1);
    check("t3_head", tdata[0], 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t3_hold_data", tdata[0], 0);
    end
    tready[0] = 1'b1;
    drain("t3_drain", 40);
    check("t3_count_empty", 32'(buf_count[0]), 0);

    // Latency 2: enable dropped with two reads in flight.
    do_reset();
    tready[1] = 1'b1;
    load(1, 32'hA1, 1'b1);
    load(1, 32'hA2, 1'b1);
    for (int i = 0; i < 4; i++) load(1, 32'hB0 + 32'(i), 1'b0);
    enable[1] = 1'b1;
    tick();
    check("t4_rd_en_second", 32'(fifo_rd_en[1]), 1);
    tick();
    enable[1] = 1'b0;
    #1;
    check("t4_rd_en_off", 32'(fifo_rd_en[1]), 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("t4_no_more_reads", 32'(fifo_rd_en[1]), 0);
    end
    drain("t4_drain", 10);
    check("t4_count_empty", 32'(buf_count[1]), 0);

    // Latency 2 with randomly toggling tready.
    do_reset();
    for (int i = 0; i < 20; i++) load(1, 32'h100 + 32'(i), 1'b1);
    enable[1] = 1'b1;
    for (int k = 0; k < 120; k++) begin
      tready[1] = 1'($urandom_range(0, 1));
      tick();
    end
    tready[1] = 1'b1;
    drain("t2_drain", 60);

    // Always-valid with an empty FIFO, then one real word.
    do_reset();
    enable[2] = 1'b1;
    tick();
    check("t5_valid_idle", 32'(tvalid[2]), 1);
    check("t5_data_idle", tdata[2], 0);
    check("t5_uflow_idle", 32'(underflow[2]), 0);
    tready[2] = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      check("t5_uflow_pulse", 32'(underflow[2]), 1);
      check("t5_valid", 32'(tvalid[2]), 1);
      check("t5_data_zero", tdata[2], 0);
      tick();
    end
    tready[2] = 1'b0;
    load(2, 32'hABCD_1234, 1'b1);
    tick();
    check("t5_uflow_stop", 32'(underflow[2]), 0);
    tick();
    check("t5_word_landed", tdata[2], 32'hABCD_1234);
    check("t5_word_count", 32'(buf_count[2]), 1);
    tready[2] = 1'b1;
    drain("t5_drain", 10);
    tready[2] = 1'b0;

    // Reset with a read in flight: late FIFO data must never surface.
    do_reset();
    tready[0] = 1'b1;
    load(0, 32'h55, 1'b0);
    load(0, 32'h66, 1'b0);
    enable[0] = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(tvalid[0]), 0);
    check("t6_rst_data", tdata[0], 0);
    check("t6_rst_count", 32'(buf_count[0]), 0);
    check("t6_rst_rd_en", 32'(fifo_rd_en[0]), 0);
    check("t6_rst_uflow", 32'(underflow[0]), 0);
    tick(2);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t6_post_valid", 32'(tvalid[0]), 0);
      check("t6_post_data", tdata[0], 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
